hilo_muldiv_unit: RTL and testbench
===================================

# hilo_muldiv_unit

Multi-cycle multiply/divide unit that owns the architectural HI/LO registers of the MIPS core. The decode stage issues MULT/MULTU/DIV/DIVU/MTHI/MTLO into it with a start/busy handshake. It serves MFHI/MFLO reads and stalls them while a computation is in flight. It replaces single-cycle `*`, `/` and `%` in the datapath with a radix-2 iterative engine: 32 iterations, one per clock.

## Interface
Parameters: none (fixed 32-bit datapath).

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  issue strobe; sampled only in IDLE
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved
- op1  in  32  rs operand (multiplicand / dividend / MTHI-MTLO data)
- op2  in  32  rt operand (multiplier / divisor)
- busy  out  1  high while a mult/div is in progress
- done  out  1  one-cycle pulse when HI/LO have just been updated
- hi  out  32  HI register
- lo  out  32  LO register
- mf_req  in  1  MFHI/MFLO read request
- mf_sel  in  1  0 = LO, 1 = HI
- mf_data  out  32  mf_sel ? hi : lo (combinational)
- mf_stall  out  1  mf_req & busy (combinational)

## Operation
- States: IDLE, CALC, FIX.
- IDLE, start=1, op in {000..011}:
  - latch operands; signed ops latch magnitudes plus result-sign flags; count=0
  - go to CALC
- IDLE, start=1, op=100/101:
  - write op1 into HI/LO at that edge
  - pulse done the next cycle; stay IDLE
- IDLE, start=1, op=110/111: ignored; no state change, no done.
- CALC, multiply: shift-add on 32-bit magnitudes into a 64-bit accumulator, one multiplier bit per cycle.
- CALC, divide: restoring division, one quotient bit per cycle, 33-bit partial remainder.
- CALC exits to FIX when count reaches 31.
- FIX, then back to IDLE:
  - MULT: negate the 64-bit product if operand signs differ
  - DIV: negate quotient if signs differ; remainder takes the dividend's sign
  - write {HI,LO} = {product[63:32], product[31:0]} or {remainder, quotient}
- start while busy: ignored. The issuing stage must hold the instruction until busy=0.
- Divide by zero, signed or unsigned: LO=32'hFFFFFFFF, HI=op1. Full latency still applies.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- HI/LO change only at a FIX edge or an MTHI/MTLO edge.

## Timing
- Reset, async, any state:
  - state=IDLE; busy=0; done=0; hi=0; lo=0; internal accumulators/counter cleared
  - an in-flight op is discarded; HI/LO are not written
- Mult/div with start sampled at edge E0:
  - busy=1 from after E0 through E33 (33 cycles)
  - CALC occupies E1..E32; FIX edge is E33
  - hi/lo hold the new values after E33, the same cycle done=1 and busy=0
- Back-to-back: a new start may be sampled at E34 (the done cycle), since the state is IDLE.
- MTHI/MTLO: register written at the sampling edge; done high for the following cycle; busy stays 0.
- mf_data reflects the register value of the current cycle; no forwarding of same-edge writes.
- mf_stall deasserts in the done cycle, and mf_data is then already valid.

## Test plan
- MULT op1=0xFFFFFFFD (-3), op2=5 -> busy high exactly 33 cycles; done; HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Then MULT same operands -> HI=0, LO=1.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 7/0 -> LO=0xFFFFFFFF, HI=7.
  - DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
- During a DIVU, assert mf_req=1/mf_sel=1 and a second start (MTLO 0x1234):
  - mf_stall=1 every busy cycle; second start ignored; LO holds the DIVU quotient afterwards
  - a later MTLO 0x1234 in IDLE -> LO=0x1234 next cycle, done pulse
- Drop rst_n at CALC cycle 10 of a MULT with prior HI/LO=0xAAAA5555 -> immediately busy=0, hi=lo=0.
  - after release, a new MULTU 3×4 -> LO=12, HI=0 at done.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register owner for the MIPS core: iterative radix-2 multiply/divide
// (32 iterations, one per clock) plus MTHI/MTLO writes and MFHI/MFLO reads.
module hilo_muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    input  logic        mf_req,
    input  logic        mf_sel,
    output logic [31:0] mf_data,
    output logic        mf_stall
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        is_div_q, is_div_d;
    logic        neg_res_q, neg_res_d;   // negate product / quotient at FIX
    logic        neg_rem_q, neg_rem_d;   // remainder takes the dividend's sign
    logic        div0_q, div0_d;
    logic [31:0] opb_q, opb_d;           // multiplicand or divisor magnitude
    logic [63:0] prod_q, prod_d;         // upper: partial product, lower: multiplier
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;           // dividend bits shift out, quotient bits shift in

    logic        signed_op;
    logic [31:0] mag1, mag2;
    logic [32:0] mul_sum;
    logic [32:0] rem_sh;
    logic [32:0] trial;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    always_comb begin
        signed_op = ~op[0];
        mag1      = (signed_op && op1[31]) ? (~op1 + 32'd1) : op1;
        mag2      = (signed_op && op2[31]) ? (~op2 + 32'd1) : op2;

        mul_sum   = {1'b0, prod_q[63:32]} + {1'b0, (prod_q[0] ? opb_q : 32'd0)};
        rem_sh    = {rem_q, quo_q[31]};
        trial     = rem_sh - {1'b0, opb_q};

        prod_fix  = neg_res_q ? (~prod_q + 64'd1) : prod_q;
        quo_fix   = div0_q ? 32'hFFFF_FFFF : (neg_res_q ? (~quo_q + 32'd1) : quo_q);
        rem_fix   = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        opb_d     = opb_q;
        prod_d    = prod_q;
        rem_d     = rem_q;
        quo_d     = quo_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    unique case (op)
                        OP_MULT, OP_MULTU: begin
                            is_div_d  = 1'b0;
                            neg_res_d = signed_op & (op1[31] ^ op2[31]);
                            neg_rem_d = 1'b0;
                            div0_d    = 1'b0;
                            opb_d     = mag1;
                            prod_d    = {32'd0, mag2};
                            count_d   = 5'd0;
                            state_d   = S_CALC;
                        end
                        OP_DIV, OP_DIVU: begin
                            is_div_d  = 1'b1;
                            neg_res_d = signed_op & (op1[31] ^ op2[31]);
                            neg_rem_d = signed_op & op1[31];
                            div0_d    = (op2 == 32'd0);
                            opb_d     = mag2;
                            rem_d     = 32'd0;
                            quo_d     = mag1;
                            count_d   = 5'd0;
                            state_d   = S_CALC;
                        end
                        OP_MTHI: begin
                            hi_d   = op1;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = op1;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_CALC: begin
                if (is_div_q) begin
                    // Restoring step: keep the subtraction only if it did not borrow.
                    if (!trial[32]) begin
                        rem_d = trial[31:0];
                        quo_d = {quo_q[30:0], 1'b1};
                    end else begin
                        rem_d = rem_sh[31:0];
                        quo_d = {quo_q[30:0], 1'b0};
                    end
                end else begin
                    prod_d = {mul_sum, prod_q[31:1]};
                end
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            count_q   <= 5'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            opb_q     <= 32'd0;
            prod_q    <= 64'd0;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            opb_q     <= opb_d;
            prod_q    <= prod_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign mf_data  = mf_sel ? hi_q : lo_q;
    assign mf_stall = mf_req & busy;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: arithmetic reference model with a
// per-cycle compare process, plus directed vectors with literal expectations.
module tb_hilo_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] op1 = 32'd0;
    logic [31:0] op2 = 32'd0;
    logic        mf_req = 1'b0;
    logic        mf_sel = 1'b0;
    logic        busy, done, mf_stall;
    logic [31:0] hi, lo, mf_data;

    int vec_cnt = 0;
    int err_cnt = 0;

    hilo_muldiv_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .op1      (op1),
        .op2      (op2),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .mf_req   (mf_req),
        .mf_sel   (mf_sel),
        .mf_data  (mf_data),
        .mf_stall (mf_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result {HI, LO} from plain integer arithmetic.
    function automatic logic [63:0] model_result(input logic [2:0] mop, input logic [31:0] a,
                                                 input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        model_result = 64'd0;
        case (mop)
            3'd0: begin
                q = sa * sb;
                model_result = q;
            end
            3'd1: begin
                p = ua * ub;
                model_result = p;
            end
            3'd2: begin
                if (b == 32'd0) model_result = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    model_result = {r[31:0], q[31:0]};
                end
            end
            3'd3: begin
                if (b == 32'd0) model_result = {a, 32'hFFFF_FFFF};
                else model_result = {a % b, a / b};
            end
            default: model_result = 64'd0;
        endcase
    endfunction

    // Model: a pending result lands 33 edges after issue; MTHI/MTLO land at once.
    logic [31:0] m_hi, m_lo, pend_hi, pend_lo;
    logic        m_done;
    int          m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi    <= 32'd0;
            m_lo    <= 32'd0;
            m_done  <= 1'b0;
            m_left  <= 0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
        end else begin
            m_done <= 1'b0;
            if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_hi   <= pend_hi;
                    m_lo   <= pend_lo;
                    m_done <= 1'b1;
                end
            end else if (start) begin
                if (op <= 3'd3) begin
                    m_left <= 33;
                    {pend_hi, pend_lo} <= model_result(op, op1, op2);
                end else if (op == 3'd4) begin
                    m_hi   <= op1;
                    m_done <= 1'b1;
                end else if (op == 3'd5) begin
                    m_lo   <= op1;
                    m_done <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy",     {31'd0, busy},     {31'd0, (m_left != 0)});
            check("done",     {31'd0, done},     {31'd0, m_done});
            check("hi",       hi,                m_hi);
            check("lo",       lo,                m_lo);
            check("mf_data",  mf_data,           mf_sel ? m_hi : m_lo);
            check("mf_stall", {31'd0, mf_stall}, {31'd0, mf_req && (m_left != 0)});
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        op1   = a;
        op2   = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for done (bounded); optionally pulses an MTLO start at loop index inject_at.
    task automatic wait_done(input int inject_at, output int busy_cyc, output int stall_cyc);
        busy_cyc  = 0;
        stall_cyc = 0;
        for (int i = 0; i < 100; i++) begin
            if (done) break;
            if (busy) busy_cyc++;
            if (mf_stall) stall_cyc++;
            if (i == inject_at) begin
                start = 1'b1;
                op    = 3'd5;
                op1   = 32'h0000_1234;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int bc, sc;
        issue(o, a, b);
        wait_done(-1, bc, sc);
        $display("txn %s op=%0d op1=%08h op2=%08h -> hi=%08h lo=%08h busy_cycles=%0d",
                 name, o, a, b, hi, lo, bc);
        check({name, "_busy_cycles"}, bc, 32'd33);
        check({name, "_hi"}, hi, exp_hi);
        check({name, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        int bc, sc;

        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("MULT_m3x5",      3'd0, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("MULTU_max",      3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("MULT_m1xm1",     3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
        run_op("MULT_big",       3'd0, 32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'h0000_0000);
        run_op("DIV_m7d2",       3'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("DIV_7dm2",       3'd2, 32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("DIVU_7d0",       3'd3, 32'd7,        32'd0,        32'h0000_0007, 32'hFFFF_FFFF);
        run_op("DIV_m5d0",       3'd2, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF);
        run_op("DIV_min_dm1",    3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("DIVU_100d7",     3'd3, 32'd100,      32'd7,        32'h0000_0002, 32'h0000_000E);
        run_op("DIVU_big",       3'd3, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF);

        // DIVU with an MFHI pending and an MTLO issued while busy.
        mf_req = 1'b1;
        mf_sel = 1'b1;
        issue(3'd3, 32'd1000, 32'd3);
        wait_done(5, bc, sc);
        $display("txn DIVU_stall 1000/3 -> hi=%08h lo=%08h stall_cycles=%0d", hi, lo, sc);
        check("stall_cycles", sc, 32'd33);
        check("stall_done_mf_stall", {31'd0, mf_stall}, 32'd0);
        check("stall_mf_data", mf_data, 32'h0000_0001);
        check("stall_lo", lo, 32'h0000_014D);
        mf_req = 1'b0;
        mf_sel = 1'b0;

        issue(3'd5, 32'h0000_1234, 32'd0);
        $display("txn MTLO 00001234 -> lo=%08h done=%0b busy=%0b", lo, done, busy);
        check("mtlo_lo", lo, 32'h0000_1234);
        check("mtlo_done", {31'd0, done}, 32'd1);
        check("mtlo_mf_data", mf_data, 32'h0000_1234);

        // Reserved op: no done, no change.
        issue(3'd7, 32'hDEAD_BEEF, 32'd0);
        $display("txn RSVD op=7 -> hi=%08h lo=%08h done=%0b", hi, lo, done);
        check("rsvd_done", {31'd0, done}, 32'd0);
        check("rsvd_lo", lo, 32'h0000_1234);

        // Reset in the middle of a MULT.
        issue(3'd4, 32'hAAAA_5555, 32'd0);
        issue(3'd5, 32'hAAAA_5555, 32'd0);
        issue(3'd0, 32'd1234, 32'd5678);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        $display("txn RESET mid-MULT -> busy=%0b hi=%08h lo=%08h", busy, hi, lo);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("MULTU_3x4", 3'd1, 32'd3, 32'd4, 32'h0000_0000, 32'h0000_000C);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
